sdram_init_ctrl: RTL and testbench

- Parametrised successor of the fixed SDRAM power-up sequencer.
- Drives the power-up wait, precharge-all, N auto-refreshes, mode-register load and an optional extended-mode-register load (mobile SDRAM) onto the packed command bus.
- The command mux in the SDRAM controller top consumes that bus.
- Supports re-initialisation on request without reset, holds a level-style done flag, and sizes address/bank fields and all timings by parameter.

---
 rtl/sdram_init_ctrl_pkg.sv | 57 +++++
 rtl/sdram_init_timer.sv | 27 ++
 rtl/sdram_init_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_sdram_init_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sdram_init_ctrl_pkg.sv
// rtl/sdram_init_ctrl_pkg.sv - shared SDRAM command encodings, init_bus layout and init FSM states
package sdram_head;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INH = 4'b1111;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    // Burst length 4, sequential, CAS latency 3
    localparam logic [12:0] DEFAULT_MODE_CODE = 13'h032;

    // Address bit that selects all banks on PRE
    localparam int A_ALL_BANKS_BIT = 10;

    typedef enum logic [3:0] {
        IDLE,
        PWR_WAIT,
        PRECH,
        WAIT_RP,
        REFRESH,
        WAIT_RFC,
        LMR,
        WAIT_MRD,
        EMRS,
        WAIT_EMRD,
        DONE
    } init_state_t;

    // init_bus = {cmd[3:0], cke, a[ROW_W-1:0], ba[BA_W-1:0]}
    function automatic int bus_width(input int row_w, input int ba_w);
        return 5 + row_w + ba_w;
    endfunction

    function automatic int a_lsb(input int ba_w);
        return ba_w;
    endfunction

    function automatic int cke_pos(input int row_w, input int ba_w);
        return ba_w + row_w;
    endfunction

    function automatic int cmd_lsb(input int row_w, input int ba_w);
        return ba_w + row_w + 1;
    endfunction

    function automatic int max_of4(input int p, input int q, input int r, input int s);
        int m;
        m = p;
        if (q > m) m = q;
        if (r > m) m = r;
        if (s > m) m = s;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_timer.sv
// rtl/sdram_init_timer.sv - loadable down-counter that stops at zero
module sdram_init_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and park at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sdram_init_ctrl.sv
// rtl/sdram_init_ctrl.sv - parametrised SDRAM power-up / re-init command sequencer
module sdram_init_ctrl
    import sdram_head::*;
#(
    parameter int              ROW_W           = 13,
    parameter int              BA_W            = 2,
    parameter int              T_POWERUP       = 20000,
    parameter int              T_RP            = 3,
    parameter int              T_RFC           = 7,
    parameter int              T_MRD           = 2,
    parameter int              NUM_REF         = 2,
    parameter logic [ROW_W-1:0] MODE_CODE      = ROW_W'(DEFAULT_MODE_CODE),
    parameter int              EMR_EN          = 0,
    parameter logic [ROW_W-1:0] EMR_CODE       = '0,
    parameter int              REINIT_SKIP_PWR = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               init_start,
    output logic                               init_busy,
    output logic                               init_done,
    output logic [bus_width(ROW_W, BA_W)-1:0]  init_bus
);

    localparam int TMR_W = $clog2(max_of4(T_POWERUP, T_RP, T_RFC, T_MRD) + 1);
    localparam int REF_W = $clog2(NUM_REF + 1);

    localparam logic [TMR_W-1:0] LD_PWR = TMR_W'(T_POWERUP - 1);
    localparam logic [TMR_W-1:0] LD_RP  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] LD_RFC = TMR_W'(T_RFC - 1);
    localparam logic [TMR_W-1:0] LD_MRD = TMR_W'(T_MRD - 1);

    localparam logic [REF_W-1:0] REF_LAST    = REF_W'(NUM_REF);
    localparam logic [ROW_W-1:0] A_ALL_BANKS = ROW_W'(1) << A_ALL_BANKS_BIT;
    localparam logic [BA_W-1:0]  BA_EMR      = BA_W'(2);

    if (T_POWERUP < 1 || T_RP < 1 || T_RFC < 1 || T_MRD < 1 ||
        NUM_REF < 1 || ROW_W < 11 || BA_W < 2) begin : g_param_check
        $fatal(1, "sdram_init_ctrl: illegal parameter set");
    end

    init_state_t       state_q, state_d;
    logic [3:0]        cmd_q, cmd_d;
    logic              cke_q, cke_d;
    logic [ROW_W-1:0]  a_q, a_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [REF_W-1:0]  ref_cnt_q;
    logic              ref_clr, ref_inc;
    logic              tmr_load, tmr_zero;
    logic [TMR_W-1:0]  tmr_value;

    sdram_init_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    // State, registered command bus and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= CMD_INH;
            cke_q   <= 1'b0;
            a_q     <= '0;
            ba_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cke_q   <= cke_d;
            a_q     <= a_d;
            ba_q    <= ba_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Count refreshes issued in the current sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
        end else if (ref_clr) begin
            ref_cnt_q <= '0;
        end else if (ref_inc) begin
            ref_cnt_q <= ref_cnt_q + REF_W'(1);
        end
    end

    // Next state and next bus value; each command is driven on the edge that enters
    // its own state, so a command state may hand straight to the next command when
    // its interval is a single cycle.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cke_q ? CMD_NOP : CMD_INH;
        cke_d     = cke_q;
        a_d       = '0;
        ba_d      = '0;
        busy_d    = busy_q;
        done_d    = done_q;
        tmr_load  = 1'b0;
        tmr_value = LD_PWR;
        ref_clr   = 1'b0;
        ref_inc   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (init_start) begin
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    if (state_q == DONE && REINIT_SKIP_PWR != 0) begin
                        state_d = PRECH;
                    end else begin
                        state_d   = PWR_WAIT;
                        cke_d     = 1'b0;
                        cmd_d     = CMD_INH;
                        tmr_load  = 1'b1;
                        tmr_value = LD_PWR;
                    end
                end
            end

            PWR_WAIT: begin
                if (tmr_zero) begin
                    state_d = PRECH;
                    cke_d   = 1'b1;
                    cmd_d   = CMD_NOP;
                end
            end

            // One NOP cycle with CKE high before precharge-all
            PRECH: begin
                state_d   = WAIT_RP;
                cmd_d     = CMD_PRE;
                a_d       = A_ALL_BANKS;
                tmr_load  = 1'b1;
                tmr_value = LD_RP;
                ref_clr   = 1'b1;
            end

            WAIT_RP: begin
                if (tmr_zero) begin
                    state_d   = REFRESH;
                    cmd_d     = CMD_REF;
                    tmr_load  = 1'b1;
                    tmr_value = LD_RFC;
                    ref_inc   = 1'b1;
                end
            end

            REFRESH, WAIT_RFC: begin
                if (!tmr_zero) begin
                    state_d = WAIT_RFC;
                end else if (ref_cnt_q != REF_LAST) begin
                    state_d   = REFRESH;
                    cmd_d     = CMD_REF;
                    tmr_load  = 1'b1;
                    tmr_value = LD_RFC;
                    ref_inc   = 1'b1;
                end else begin
                    state_d   = LMR;
                    cmd_d     = CMD_LMR;
                    a_d       = MODE_CODE;
                    tmr_load  = 1'b1;
                    tmr_value = LD_MRD;
                end
            end

            LMR, WAIT_MRD: begin
                if (!tmr_zero) begin
                    state_d = WAIT_MRD;
                end else if (EMR_EN != 0) begin
                    state_d   = EMRS;
                    cmd_d     = CMD_LMR;
                    a_d       = EMR_CODE;
                    ba_d      = BA_EMR;
                    tmr_load  = 1'b1;
                    tmr_value = LD_MRD;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            EMRS, WAIT_EMRD: begin
                if (!tmr_zero) begin
                    state_d = WAIT_EMRD;
                end else begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign init_busy = busy_q;
    assign init_done = done_q;
    assign init_bus[cmd_lsb(ROW_W, BA_W) +: 4]     = cmd_q;
    assign init_bus[cke_pos(ROW_W, BA_W)]          = cke_q;
    assign init_bus[a_lsb(BA_W) +: ROW_W]          = a_q;
    assign init_bus[BA_W-1:0]                      = ba_q;

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// tb/tb_sdram_init_ctrl.sv - table-driven bench for sdram_init_ctrl across four parameter sets
module tb_sdram_init_ctrl;
    import sdram_head::*;

    typedef struct packed {
        logic [3:0]  cmd;
        logic        cke;
        logic [12:0] a;
        logic [1:0]  ba;
        logic        busy;
        logic        done;
    } obs_t;

    // Scenario: expected background behaviour of one DUT over a window of edges
    typedef struct {
        int dut;
        int first;
        int last;
        int cke_at;
        int busy_from;
        int done_at;
    } sc_t;

    // Command event expected at one edge of one scenario
    typedef struct {
        int          sc;
        int          at;
        logic [3:0]  cmd;
        logic [12:0] a;
        logic [1:0]  ba;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_start;
    logic        busy_s [4];
    logic        done_s [4];
    logic [19:0] bus_a, bus_b, bus_c;
    logic [18:0] bus_d;

    obs_t cap [4][81];
    sc_t  scs [7];
    ev_t  evs [$];
    int   vectors = 0;
    int   misses  = 0;

    always #5 clk = ~clk;

    sdram_init_ctrl #(.T_POWERUP(10), .T_RP(3), .T_RFC(7), .T_MRD(2), .NUM_REF(2),
                      .EMR_EN(0), .REINIT_SKIP_PWR(1)) u_a (
        .clk(clk), .rst(rst), .init_start(init_start),
        .init_busy(busy_s[0]), .init_done(done_s[0]), .init_bus(bus_a));

    sdram_init_ctrl #(.T_POWERUP(10), .T_RP(3), .T_RFC(7), .T_MRD(2), .NUM_REF(2),
                      .EMR_EN(1), .EMR_CODE(13'h020), .REINIT_SKIP_PWR(1)) u_b (
        .clk(clk), .rst(rst), .init_start(init_start),
        .init_busy(busy_s[1]), .init_done(done_s[1]), .init_bus(bus_b));

    sdram_init_ctrl #(.T_POWERUP(10), .T_RP(3), .T_RFC(7), .T_MRD(2), .NUM_REF(2),
                      .EMR_EN(0), .REINIT_SKIP_PWR(0)) u_c (
        .clk(clk), .rst(rst), .init_start(init_start),
        .init_busy(busy_s[2]), .init_done(done_s[2]), .init_bus(bus_c));

    sdram_init_ctrl #(.ROW_W(12), .BA_W(2), .T_POWERUP(10), .T_RP(3), .T_RFC(7), .T_MRD(2),
                      .NUM_REF(8), .EMR_EN(0), .REINIT_SKIP_PWR(1)) u_d (
        .clk(clk), .rst(rst), .init_start(init_start),
        .init_busy(busy_s[3]), .init_done(done_s[3]), .init_bus(bus_d));

    function automatic obs_t get_obs(input int d);
        obs_t o;
        case (d)
            0:       o = '{bus_a[19:16], bus_a[15], bus_a[14:2], bus_a[1:0], busy_s[0], done_s[0]};
            1:       o = '{bus_b[19:16], bus_b[15], bus_b[14:2], bus_b[1:0], busy_s[1], done_s[1]};
            2:       o = '{bus_c[19:16], bus_c[15], bus_c[14:2], bus_c[1:0], busy_s[2], done_s[2]};
            default: o = '{bus_d[18:15], bus_d[14], {1'b0, bus_d[13:2]}, bus_d[1:0], busy_s[3], done_s[3]};
        endcase
        return o;
    endfunction

    function automatic string obs_str(input obs_t o);
        return $sformatf("cmd=%b cke=%b a=%h ba=%0d busy=%b done=%b",
                         o.cmd, o.cke, o.a, o.ba, o.busy, o.done);
    endfunction

    task automatic cmp(input string name, input int d, input int e, input obs_t got, input obs_t want);
        vectors++;
        if (got !== want) begin
            misses++;
            $display("FAIL %s dut%0d edge %0d: got %s, expected %s",
                     name, d, e, obs_str(got), obs_str(want));
        end
    endtask

    task automatic check_reset(input string name);
        obs_t want;
        want = '{CMD_INH, 1'b0, 13'h0, 2'd0, 1'b0, 1'b0};
        for (int d = 0; d < 4; d++) cmp(name, d, -1, get_obs(d), want);
    endtask

    // PRE at base, REFs at base+3 and base+10, LMR at base+17 (T_RP=3, T_RFC=7, NUM_REF=2)
    task automatic add_core(input int sc, input int base);
        evs.push_back('{sc, base,      CMD_PRE, 13'h400, 2'd0});
        evs.push_back('{sc, base + 3,  CMD_REF, 13'h000, 2'd0});
        evs.push_back('{sc, base + 10, CMD_REF, 13'h000, 2'd0});
        evs.push_back('{sc, base + 17, CMD_LMR, 13'h032, 2'd0});
    endtask

    // Start request sampled at relative edge 0, then per-edge capture of all DUTs
    task automatic capture(input int last, input int hold, input int p1, input int p2);
        init_start = (hold > 0) || (p1 == 0) || (p2 == 0);
        for (int e = 0; e <= last; e++) begin
            @(posedge clk);
            @(negedge clk);
            for (int d = 0; d < 4; d++) cap[d][e] = get_obs(d);
            init_start = ((e + 1) < hold) || ((e + 1) == p1) || ((e + 1) == p2);
        end
    endtask

    task automatic check_sc(input int sc, input int lim);
        sc_t  s;
        obs_t want;
        s = scs[sc];
        for (int e = s.first; e <= s.last && e <= lim; e++) begin
            want.cke  = (e >= s.cke_at);
            want.cmd  = want.cke ? CMD_NOP : CMD_INH;
            want.a    = '0;
            want.ba   = '0;
            want.busy = (e >= s.busy_from) && (e < s.done_at);
            want.done = (e >= s.done_at);
            foreach (evs[i]) begin
                if (evs[i].sc == sc && evs[i].at == e) begin
                    want.cmd = evs[i].cmd;
                    want.a   = evs[i].a;
                    want.ba  = evs[i].ba;
                end
            end
            cmp($sformatf("sc%0d", sc), s.dut, e, cap[s.dut][e], want);
        end
    endtask

    initial begin
        // dut, first, last, cke_at, busy_from, done_at
        scs[0] = '{0, 0, 39, 10, 0, 30};    // cold, base config
        scs[1] = '{0, 40, 80, 0, 40, 60};   // re-init skipping power-up
        scs[2] = '{1, 0, 39, 10, 0, 32};    // cold with EMRS
        scs[3] = '{1, 40, 80, 0, 40, 62};   // re-init with EMRS
        scs[4] = '{2, 0, 39, 10, 0, 30};    // cold, full re-init config
        scs[5] = '{2, 40, 80, 50, 40, 70};  // re-init with power-up wait
        scs[6] = '{3, 0, 80, 10, 0, 72};    // eight refreshes, 12-bit row

        add_core(0, 11);
        add_core(1, 41);
        add_core(2, 11);
        evs.push_back('{2, 30, CMD_LMR, 13'h020, 2'd2});
        add_core(3, 41);
        evs.push_back('{3, 60, CMD_LMR, 13'h020, 2'd2});
        add_core(4, 11);
        add_core(5, 51);
        evs.push_back('{6, 11, CMD_PRE, 13'h400, 2'd0});
        for (int k = 0; k < 8; k++) evs.push_back('{6, 14 + 7 * k, CMD_REF, 13'h000, 2'd0});
        evs.push_back('{6, 70, CMD_LMR, 13'h032, 2'd0});

        // Reset state, then start raised in the cycle reset is released
        rst        = 1'b1;
        init_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        capture(80, 1, 40, -1);
        for (int sc = 0; sc < 7; sc++) check_sc(sc, 1000);

        // Asynchronous reset between edges 20 and 21 of a running sequence
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        capture(20, 1, -1, -1);
        check_sc(0, 20);
        rst = 1'b1;
        #1;
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        capture(80, 1, -1, -1);
        check_sc(0, 1000);
        check_sc(2, 1000);
        check_sc(4, 1000);
        check_sc(6, 1000);

        // Start held for five cycles plus a stray pulse while busy
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        capture(80, 5, 15, -1);
        check_sc(0, 1000);
        check_sc(2, 1000);
        check_sc(4, 1000);
        check_sc(6, 1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
